quad_step_decoder: RTL and testbench

- Quadrature (A/B) encoder front end. Converts two asynchronous phase inputs into single-cycle up/down step pulses plus a direction level.
- These pulses are the step-source end of the 8-bit up/down counter interface.
- Also keeps its own 8-bit position (loadable, wrap-around) and a sticky illegal-transition flag.

---
 rtl/quad_step_decoder.sv | 118 +++++++++++
 tb/tb_quad_step_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronises the phase inputs, decodes Gray-code steps into
// one-cycle up/down pulses, and keeps a loadable wrap-around position and a sticky error flag.
module quad_step_decoder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SETTLE = 3
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] preset,
    output logic             up,
    output logic             down,
    output logic             dir,
    output logic             err,
    output logic [WIDTH-1:0] position
);

    localparam int unsigned CntW = $clog2(SETTLE + 1);

    logic             a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [1:0]       cur;
    logic [1:0]       prev_q;
    logic [CntW-1:0]  settle_q, settle_d;
    logic             settled;
    logic             step_fwd, step_rev, illegal;
    logic             up_q, up_d, down_q, down_d, dir_q, dir_d, err_q, err_d;
    logic [WIDTH-1:0] position_q, position_d;

    assign cur     = {a_s2_q, b_s2_q};
    assign settled = (settle_q == CntW'(SETTLE));

    // Phase written {A,B}; forward order is 00 -> 10 -> 11 -> 01 -> 00.
    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        illegal  = 1'b0;
        if (settled) begin
            case ({prev_q, cur})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev = 1'b1;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal  = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        settle_d   = settle_q;
        up_d       = enable & step_fwd;
        down_d     = enable & step_rev;
        dir_d      = dir_q;
        err_d      = err_q;
        position_d = position_q;

        if (!settled) begin
            settle_d = settle_q + CntW'(1);
        end

        if (enable && step_fwd) begin
            dir_d = 1'b1;
        end else if (enable && step_rev) begin
            dir_d = 1'b0;
        end

        // Load wins over counting and over a simultaneous illegal transition.
        if (load) begin
            position_d = preset;
            err_d      = 1'b0;
        end else begin
            if (enable && step_fwd) begin
                position_d = position_q + WIDTH'(1);
            end else if (enable && step_rev) begin
                position_d = position_q - WIDTH'(1);
            end
            if (illegal) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            a_s1_q     <= 1'b0;
            a_s2_q     <= 1'b0;
            b_s1_q     <= 1'b0;
            b_s2_q     <= 1'b0;
            prev_q     <= 2'b00;
            settle_q   <= '0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            position_q <= '0;
        end else begin
            a_s1_q     <= a_in;
            a_s2_q     <= a_s1_q;
            b_s1_q     <= b_in;
            b_s2_q     <= b_s1_q;
            prev_q     <= cur;
            settle_q   <= settle_d;
            up_q       <= up_d;
            down_q     <= down_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            position_q <= position_d;
        end
    end

    assign up       = up_q;
    assign down     = down_q;
    assign dir      = dir_q;
    assign err      = err_q;
    assign position = position_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: table of phase steps with hand-computed results, corner-case
// sequences, and a random phase walk checked every cycle against an edge-indexed reference model.
module tb_quad_step_decoder;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned SETTLE = 3;

    logic             clock = 1'b0;
    logic             clear_n;
    logic             a_in, b_in, enable, load;
    logic [WIDTH-1:0] preset;
    logic             up, down, dir, err;
    logic [WIDTH-1:0] position;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    quad_step_decoder #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .a_in     (a_in),
        .b_in     (b_in),
        .enable   (enable),
        .load     (load),
        .preset   (preset),
        .up       (up),
        .down     (down),
        .dir      (dir),
        .err      (err),
        .position (position)
    );

    // Reference model: phases sampled at each edge since release; at edge n the decoder
    // compares the samples from edges n-3 and n-2 (zero before release).
    logic [1:0]       ph_hist[$];
    int               n_edges;
    logic             m_up, m_down, m_dir, m_err;
    logic [WIDTH-1:0] m_pos;

    typedef struct {
        logic [1:0]       ph;
        logic             en;
        logic             ld;
        logic [WIDTH-1:0] pre;
        logic [WIDTH-1:0] pos;
        logic             err;
        logic             dir;
        int               ups;
        int               downs;
    } vec_t;

    vec_t       tbl[20];
    logic [1:0] seq[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int phase_idx(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        ph_hist.delete();
        n_edges = 0;
        m_up = 0; m_down = 0; m_dir = 0; m_err = 0; m_pos = '0;
    endtask

    task automatic tick();
        logic [1:0]       ph_now, cur, prv;
        logic             en_now, ld_now, rst_now;
        logic [WIDTH-1:0] pre_now;
        int               step;
        @(posedge clock);
        ph_now = {a_in, b_in}; en_now = enable; ld_now = load; pre_now = preset;
        rst_now = clear_n;
        if (!rst_now) begin
            model_reset();
        end else begin
            n_edges++;
            ph_hist.push_back(ph_now);
            if (ph_hist.size() > 4) void'(ph_hist.pop_front());
            cur  = (n_edges >= 3) ? ph_hist[ph_hist.size()-3] : 2'b00;
            prv  = (n_edges >= 4) ? ph_hist[ph_hist.size()-4] : 2'b00;
            step = (n_edges >= int'(SETTLE) + 1) ? (phase_idx(cur) - phase_idx(prv) + 4) % 4 : 0;
            m_up   = en_now && step == 1;
            m_down = en_now && step == 3;
            if (m_up) m_dir = 1'b1;
            if (m_down) m_dir = 1'b0;
            if (ld_now) begin
                m_pos = pre_now;
                m_err = 1'b0;
            end else begin
                if (m_up) m_pos = m_pos + 1'b1;
                if (m_down) m_pos = m_pos - 1'b1;
                if (step == 2) m_err = 1'b1;
            end
        end
        #1;
        check("up", up, m_up);
        check("down", down, m_down);
        check("dir", dir, m_dir);
        check("err", err, m_err);
        check("pos", position, m_pos);
    endtask

    task automatic set_phase(input logic [1:0] p);
        a_in = p[1];
        b_in = p[0];
    endtask

    task automatic do_reset(input logic [1:0] ph_rel);
        clear_n = 1'b0;
        #1;
        check("rst_up", up, 0);
        check("rst_down", down, 0);
        check("rst_dir", dir, 0);
        check("rst_err", err, 0);
        check("rst_pos", position, 0);
        set_phase(ph_rel);
        tick();
        tick();
        clear_n = 1'b1;
    endtask

    initial begin
        int ups, downs, cur_idx, hold, k;
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        //           ph     en  ld  pre    pos    err dir ups downs
        tbl[0]  = '{2'b10, 1, 0, 8'h00, 8'h01, 0, 1, 1, 0};
        tbl[1]  = '{2'b11, 1, 0, 8'h00, 8'h02, 0, 1, 1, 0};
        tbl[2]  = '{2'b01, 1, 0, 8'h00, 8'h03, 0, 1, 1, 0};
        tbl[3]  = '{2'b00, 1, 0, 8'h00, 8'h04, 0, 1, 1, 0};
        tbl[4]  = '{2'b00, 1, 1, 8'h01, 8'h01, 0, 1, 0, 0};
        tbl[5]  = '{2'b01, 1, 0, 8'h00, 8'h00, 0, 0, 0, 1};
        tbl[6]  = '{2'b11, 1, 0, 8'h00, 8'hFF, 0, 0, 0, 1};
        tbl[7]  = '{2'b10, 1, 0, 8'h00, 8'hFE, 0, 0, 0, 1};
        tbl[8]  = '{2'b00, 1, 0, 8'h00, 8'hFD, 0, 0, 0, 1};
        tbl[9]  = '{2'b00, 1, 1, 8'hFF, 8'hFF, 0, 0, 0, 0};
        tbl[10] = '{2'b10, 1, 0, 8'h00, 8'h00, 0, 1, 1, 0};
        tbl[11] = '{2'b00, 1, 0, 8'h00, 8'hFF, 0, 0, 0, 1};
        tbl[12] = '{2'b11, 1, 0, 8'h00, 8'hFF, 1, 0, 0, 0};
        tbl[13] = '{2'b01, 1, 0, 8'h00, 8'h00, 1, 1, 1, 0};
        tbl[14] = '{2'b00, 1, 0, 8'h00, 8'h01, 1, 1, 1, 0};
        tbl[15] = '{2'b00, 1, 1, 8'h10, 8'h10, 0, 1, 0, 0};
        tbl[16] = '{2'b10, 0, 0, 8'h00, 8'h10, 0, 1, 0, 0};
        tbl[17] = '{2'b11, 0, 0, 8'h00, 8'h10, 0, 1, 0, 0};
        tbl[18] = '{2'b01, 1, 0, 8'h00, 8'h11, 0, 1, 1, 0};
        tbl[19] = '{2'b00, 1, 0, 8'h00, 8'h12, 0, 1, 1, 0};

        clear_n = 1'b1; a_in = 0; b_in = 0; enable = 1; load = 0; preset = '0;
        model_reset();
        #2;
        do_reset(2'b00);
        for (int c = 0; c < 6; c++) tick();

        // Table of phase steps, 6 clocks each; load applies on the first clock only.
        for (int i = 0; i < 20; i++) begin
            set_phase(tbl[i].ph);
            enable = tbl[i].en;
            load   = tbl[i].ld;
            preset = tbl[i].pre;
            ups = 0; downs = 0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (c == 0) load = 1'b0;
                ups += int'(up);
                downs += int'(down);
            end
            check($sformatf("tbl%0d_pos", i), position, tbl[i].pos);
            check($sformatf("tbl%0d_err", i), err, tbl[i].err);
            check($sformatf("tbl%0d_dir", i), dir, tbl[i].dir);
            check($sformatf("tbl%0d_ups", i), ups, tbl[i].ups);
            check($sformatf("tbl%0d_downs", i), downs, tbl[i].downs);
        end

        // Step and load landing on the same edge.
        set_phase(2'b10);
        tick();
        tick();
        load = 1'b1; preset = 8'h40;
        tick();
        check("ldstep_up", up, 1);
        check("ldstep_pos", position, 8'h40);
        load = 1'b0;
        tick();
        check("ldstep_hold_pos", position, 8'h40);
        check("ldstep_hold_up", up, 0);

        // Reset mid-sequence with a nonzero phase at release.
        set_phase(2'b11);
        tick();
        do_reset(2'b01);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("settle_up", up, 0);
            check("settle_down", down, 0);
        end
        for (int c = 0; c < 5; c++) tick();
        set_phase(2'b00);
        ups = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            ups += int'(up);
        end
        check("post_rst_ups", ups, 1);
        check("post_rst_pos", position, 8'h01);
        check("post_rst_dir", dir, 1);

        // Release with both phases high held: no spurious step.
        do_reset(2'b11);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("rel11_up", up, 0);
            check("rel11_down", down, 0);
            check("rel11_pos", position, 0);
            check("rel11_err", err, 0);
        end

        // Random phase walk against the model.
        cur_idx = 2;
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 99) < 2) begin
                load = 1'b0;
                cur_idx = $urandom_range(0, 3);
                do_reset(seq[cur_idx]);
            end
            k = $urandom_range(0, 9);
            cur_idx = (cur_idx + ((k < 4) ? 1 : (k < 8) ? 3 : (k < 9) ? 2 : 0)) % 4;
            set_phase(seq[cur_idx]);
            hold = $urandom_range(1, 6);
            for (int c = 0; c < hold; c++) begin
                enable = ($urandom_range(0, 9) != 0);
                load   = ($urandom_range(0, 19) == 0);
                preset = WIDTH'($urandom);
                tick();
            end
        end
        load = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
